// File: rtl/riscv_bp_gshare.sv
// -----------------------------------------------------------------------------
// riscv_bp_gshare
//
// Branch direction predictor. A pattern-history table of CNT_BITS-wide
// saturating counters is indexed either by {history, pc-bits} (CONCAT) or by
// pc-bits XOR history (XOR). After reset or flush the table is walked once and
// every entry is set to INIT_VALUE. The read side registers one prediction per
// cycle for the parcel entering ID. The write side takes resolved branches from
// EX. A write and a read of the same entry in the same cycle forward the new
// value to the output register.
//
// Ports
//   clk_i                   clock
//   rst_ni                  asynchronous active-low reset
//   flush_i                 restart table initialisation
//   bp_ready_o              table initialised, updates accepted
//   id_stall_i              hold read side
//   if_parcel_pc_i          fetch PC
//   if_parcel_bp_history_i  global history at fetch
//   bp_bp_predict_o         counter for the parcel now in ID
//   bp_bp_taken_o           MSB of bp_bp_predict_o
//   ex_pc_i                 resolved branch PC
//   bu_bp_history_i         global history of the resolved branch
//   bu_bp_predict_i         counter carried with the branch
//   bu_bp_btaken_i          branch outcome
//   bu_bp_update_i          write enable
// -----------------------------------------------------------------------------
module riscv_bp_gshare #(
    parameter int unsigned      MXLEN             = 32,
    parameter logic [MXLEN-1:0] PC_INIT           = 'h200,
    parameter bit               HAS_RVC           = 1'b0,
    parameter int unsigned      BP_GLOBAL_BITS    = 2,
    parameter int unsigned      BP_LOCAL_BITS     = 10,
    parameter int unsigned      BP_LOCAL_BITS_LSB = HAS_RVC ? 1 : 2,
    parameter int unsigned      CNT_BITS          = 2,
    parameter string            INDEX_MODE        = "CONCAT",
    parameter int unsigned      INIT_VALUE        = (1 << (CNT_BITS - 1)) - 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      flush_i,
    output logic                      bp_ready_o,

    input  logic                      id_stall_i,
    input  logic [MXLEN-1:0]          if_parcel_pc_i,
    input  logic [BP_GLOBAL_BITS-1:0] if_parcel_bp_history_i,
    output logic [CNT_BITS-1:0]       bp_bp_predict_o,
    output logic                      bp_bp_taken_o,

    input  logic [MXLEN-1:0]          ex_pc_i,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i,
    input  logic [CNT_BITS-1:0]       bu_bp_predict_i,
    input  logic                      bu_bp_btaken_i,
    input  logic                      bu_bp_update_i
);

    localparam bit          XOR_MODE = (INDEX_MODE == "XOR");
    localparam int unsigned ADR_BITS = XOR_MODE ? BP_LOCAL_BITS
                                                : BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int unsigned DEPTH    = 1 << ADR_BITS;

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] INIT_CNT = CNT_BITS'(INIT_VALUE);

    // Elaboration-time parameter checks
    if (XOR_MODE && (BP_GLOBAL_BITS > BP_LOCAL_BITS)) begin : g_bad_xor_hist
        $error("riscv_bp_gshare: BP_GLOBAL_BITS must not exceed BP_LOCAL_BITS in XOR mode");
    end
    if ((CNT_BITS < 2) || (CNT_BITS > 4)) begin : g_bad_cnt_bits
        $error("riscv_bp_gshare: CNT_BITS must be in 2..4");
    end

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    // Table index from the PC slice and global history
    function automatic logic [ADR_BITS-1:0] f_index(input logic [BP_LOCAL_BITS-1:0]  pcs,
                                                     input logic [BP_GLOBAL_BITS-1:0] hist);
        logic [BP_LOCAL_BITS-1:0] hist_ext;
        hist_ext = BP_LOCAL_BITS'(hist);
        if (XOR_MODE) begin
            return ADR_BITS'(pcs ^ hist_ext);
        end
        return ADR_BITS'({hist, pcs});
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                r_state;
    state_e                w_state_next;
    logic [ADR_BITS-1:0]   r_init_cnt;
    logic [ADR_BITS-1:0]   w_init_cnt_next;
    logic [MXLEN-1:0]      r_pc_dly;
    logic [CNT_BITS-1:0]   r_predict;
    logic [CNT_BITS-1:0]   r_pht [DEPTH];

    // -------------------------------------------------------------------------
    // Index generation
    // -------------------------------------------------------------------------
    logic [MXLEN-1:0]         w_rd_pc;
    logic [BP_LOCAL_BITS-1:0] w_rd_pcs;
    logic [BP_LOCAL_BITS-1:0] w_wr_pcs;
    logic [ADR_BITS-1:0]      w_ridx;
    logic [ADR_BITS-1:0]      w_widx;

    // While ID is stalled the read side re-uses the PC it last accepted
    assign w_rd_pc  = id_stall_i ? r_pc_dly : if_parcel_pc_i;
    assign w_rd_pcs = w_rd_pc[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS];
    assign w_wr_pcs = ex_pc_i[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS];
    assign w_ridx   = f_index(w_rd_pcs, if_parcel_bp_history_i);
    assign w_widx   = f_index(w_wr_pcs, bu_bp_history_i);

    // PC bits outside the index slice are intentionally ignored
    logic w_unused;
    assign w_unused = ^{w_rd_pc, ex_pc_i};

    // -------------------------------------------------------------------------
    // Counter update
    // -------------------------------------------------------------------------
    logic [CNT_BITS-1:0] w_new_cnt;

    always_comb begin
        w_new_cnt = bu_bp_predict_i;
        if (bu_bp_btaken_i) begin
            if (bu_bp_predict_i != CNT_MAX) begin
                w_new_cnt = bu_bp_predict_i + CNT_BITS'(1);
            end
        end else begin
            if (bu_bp_predict_i != '0) begin
                w_new_cnt = bu_bp_predict_i - CNT_BITS'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Init / run FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StInit;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        unique case (r_state)
            StInit: begin
                if (flush_i) begin
                    w_init_cnt_next = '0;
                end else if (&r_init_cnt) begin
                    w_state_next    = StRun;
                    w_init_cnt_next = '0;
                end else begin
                    w_init_cnt_next = r_init_cnt + ADR_BITS'(1);
                end
            end
            StRun: begin
                if (flush_i) begin
                    w_state_next    = StInit;
                    w_init_cnt_next = '0;
                end
            end
            default: begin
                w_state_next    = StInit;
                w_init_cnt_next = '0;
            end
        endcase
    end

    assign bp_ready_o = (r_state == StRun);

    // -------------------------------------------------------------------------
    // Table write port (shared between init walk and branch updates)
    // -------------------------------------------------------------------------
    logic                w_upd_we;
    logic                w_tbl_we;
    logic [ADR_BITS-1:0] w_tbl_wadr;
    logic [CNT_BITS-1:0] w_tbl_wdata;

    // Flush wins over a same-cycle update; updates during init are dropped
    assign w_upd_we = bu_bp_update_i && (r_state == StRun) && !flush_i;

    always_comb begin
        w_tbl_we    = w_upd_we;
        w_tbl_wadr  = w_widx;
        w_tbl_wdata = w_new_cnt;
        if (r_state == StInit) begin
            w_tbl_we    = 1'b1;
            w_tbl_wadr  = r_init_cnt;
            w_tbl_wdata = INIT_CNT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tbl_we) begin
            r_pht[w_tbl_wadr] <= w_tbl_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read side
    // -------------------------------------------------------------------------
    logic [CNT_BITS-1:0] w_rd_data;

    always_comb begin
        w_rd_data = r_pht[w_ridx];
        if (r_state == StInit) begin
            w_rd_data = INIT_CNT;
        end else if (w_upd_we && (w_widx == w_ridx)) begin
            // The table write lands at this same edge; pass the new value through
            w_rd_data = w_new_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc_dly  <= PC_INIT;
            r_predict <= INIT_CNT;
        end else if (!id_stall_i) begin
            r_pc_dly  <= if_parcel_pc_i;
            r_predict <= w_rd_data;
        end
    end

    assign bp_bp_predict_o = r_predict;
    assign bp_bp_taken_o   = r_predict[CNT_BITS-1];

endmodule
